// File: rtl/vrased_pkg.sv
// -----------------------------------------------------------------------------
// vrased_pkg
//   Definitions shared by the VRASED violation/reset path:
//     - rst_state_e     : reset controller state encoding (ST_IDLE / ST_HOLD)
//     - SRC_*           : bit positions of each monitor inside viol_req
//     - DEF_HOLD_CYCLES : default width of the system reset pulse
//     - min_width()     : register width able to hold 0..n-1, never below 1
// -----------------------------------------------------------------------------
package vrased_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } rst_state_e;

    // Monitor positions inside the viol_req vector.
    localparam int SRC_DMA  = 0;    // DMA/IRQ detector
    localparam int SRC_MEM  = 1;    // memory access-control monitor
    localparam int SRC_ATOM = 2;    // atomicity / control-flow monitor
    localparam int SRC_KEY  = 3;    // key-access monitor

    localparam int DEF_N_SRC       = 4;
    localparam int DEF_HOLD_CYCLES = 8;
    localparam int DEF_CNT_W       = 8;

    // Width of a down-counter that must hold values 0..n-1.
    function automatic int min_width(input int n);
        int w;
        w = (n > 1) ? $clog2(n) : 1;
        return w;
    endfunction

endpackage

// File: rtl/viol_edge_det.sv
// -----------------------------------------------------------------------------
// viol_edge_det
//   Per-source rising-edge detector for monitor reset requests. A request
//   held high yields a single one-cycle event; the source re-arms only once
//   it has been seen low for at least one cycle.
//
//   Ports
//     clk       in   system clock
//     rst       in   synchronous active-high reset
//     viol_req  in   [N_SRC]  level requests from the monitors
//     req_edge  out  [N_SRC]  combinational rising-edge flags
// -----------------------------------------------------------------------------
module viol_edge_det #(
    parameter int N_SRC = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] viol_req,
    output logic [N_SRC-1:0] req_edge
);

    logic [N_SRC-1:0] req_q;
    logic [N_SRC-1:0] req_d;

    always_comb begin
        req_d = viol_req;
    end

    // History resets to all ones so a request that is already asserted when
    // reset releases is treated as old news rather than a fresh violation.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_q <= {N_SRC{1'b1}};
        end else begin
            req_q <= req_d;
        end
    end

    generate
        for (genvar gi = 0; gi < N_SRC; gi++) begin : g_edge
            assign req_edge[gi] = viol_req[gi] & ~req_q[gi];
        end
    endgenerate

endmodule

// File: rtl/viol_reset_ctrl.sv
// -----------------------------------------------------------------------------
// viol_reset_ctrl
//   Turns each new monitor reset request into one fixed-width system reset
//   pulse for the openMSP430 PUC logic, and keeps debug state about the
//   violations: which sources fired, the PC at the first one, and a
//   saturating count of violation cycles. Reacting to request edges (not
//   levels) keeps a monitor that holds its request high from locking the
//   CPU in reset.
//
//   Ports
//     clk        in   system clock
//     rst        in   synchronous active-high reset
//     viol_req   in   [N_SRC]  level requests from the monitors
//     pc         in   [16]     current CPU program counter
//     cause_clr  in   one-cycle pulse clearing cause / viol_pc / viol_cnt
//     sys_rst    out  registered reset request to the CPU PUC
//     busy       out  same as sys_rst (pulse in progress)
//     cause      out  [N_SRC]  sticky per-source violation flags
//     viol_pc    out  [16]     PC at the first violation since clear
//     viol_cnt   out  [CNT_W]  saturating count of violation cycles
// -----------------------------------------------------------------------------
module viol_reset_ctrl
    import vrased_pkg::*;
#(
    parameter int N_SRC       = DEF_N_SRC,
    parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] viol_req,
    input  logic [15:0]      pc,
    input  logic             cause_clr,
    output logic             sys_rst,
    output logic             busy,
    output logic [N_SRC-1:0] cause,
    output logic [15:0]      viol_pc,
    output logic [CNT_W-1:0] viol_cnt
);

    localparam int              HC_W        = min_width(HOLD_CYCLES);
    localparam logic [HC_W-1:0] HOLD_RELOAD = HC_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

    // ------------------------------------------------------------------
    // Edge detection
    // ------------------------------------------------------------------
    logic [N_SRC-1:0] req_edge;
    logic             any_edge;

    viol_edge_det #(
        .N_SRC (N_SRC)
    ) u_edge_det (
        .clk      (clk),
        .rst      (rst),
        .viol_req (viol_req),
        .req_edge (req_edge)
    );

    assign any_edge = |req_edge;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    rst_state_e       state_q,    state_d;
    logic [HC_W-1:0]  hold_cnt_q, hold_cnt_d;
    logic             sys_rst_q,  sys_rst_d;
    logic [N_SRC-1:0] cause_q,    cause_d;
    logic [15:0]      viol_pc_q,  viol_pc_d;
    logic [CNT_W-1:0] viol_cnt_q, viol_cnt_d;

    // ------------------------------------------------------------------
    // Pulse FSM: any new edge (re)loads the hold counter, so a retrigger
    // in the middle of a pulse stretches it rather than starting a second.
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (any_edge) begin
                    state_d    = ST_HOLD;
                    hold_cnt_d = HOLD_RELOAD;
                end
            end
            ST_HOLD: begin
                if (any_edge) begin
                    hold_cnt_d = HOLD_RELOAD;
                end else if (hold_cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    hold_cnt_d = hold_cnt_q - HC_W'(1);
                end
            end
            default: begin
                state_d    = ST_IDLE;
                hold_cnt_d = '0;
            end
        endcase
        // Registered copy of the next state keeps the PUC input glitch-free.
        sys_rst_d = (state_d == ST_HOLD);
    end

    // ------------------------------------------------------------------
    // Debug registers. A clear and a new edge in the same cycle resolve in
    // favour of the edge, so a violation is never lost to a clear.
    // ------------------------------------------------------------------
    always_comb begin
        cause_d    = cause_q;
        viol_pc_d  = viol_pc_q;
        viol_cnt_d = viol_cnt_q;

        if (cause_clr) begin
            cause_d = req_edge;
        end else begin
            cause_d = cause_q | req_edge;
        end

        // First violation since clear: prior cause is empty, or being wiped.
        if (any_edge && ((cause_q == '0) || cause_clr)) begin
            viol_pc_d = pc;
        end

        if (cause_clr) begin
            viol_cnt_d = CNT_W'(any_edge);
        end else if (any_edge && (viol_cnt_q != CNT_MAX)) begin
            viol_cnt_d = viol_cnt_q + CNT_W'(1);
        end
    end

    // Reset lands in HOLD with a full count: the power-up pulse is the same
    // width as a violation pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_HOLD;
            hold_cnt_q <= HOLD_RELOAD;
            sys_rst_q  <= 1'b1;
            cause_q    <= '0;
            viol_pc_q  <= '0;
            viol_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            sys_rst_q  <= sys_rst_d;
            cause_q    <= cause_d;
            viol_pc_q  <= viol_pc_d;
            viol_cnt_q <= viol_cnt_d;
        end
    end

    assign sys_rst  = sys_rst_q;
    assign busy     = sys_rst_q;
    assign cause    = cause_q;
    assign viol_pc  = viol_pc_q;
    assign viol_cnt = viol_cnt_q;

endmodule

// File: tb/tb_viol_reset_ctrl.sv
// -----------------------------------------------------------------------------
// tb_viol_reset_ctrl
//   Two instances share one stimulus: the default configuration and a
//   CNT_W = 2 copy for saturation. A reference model tracks "cycles of reset
//   remaining" plus the debug state from the behavioural rules and is
//   compared every cycle; directed scenarios pin it with literal values.
// -----------------------------------------------------------------------------
module tb_viol_reset_ctrl;

    localparam int N_SRC = 4;
    localparam int HOLD  = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  viol_req;
    logic [15:0] pc;
    logic        cause_clr;

    logic        sys_rst,  busy;
    logic [3:0]  cause;
    logic [15:0] viol_pc;
    logic [7:0]  viol_cnt;

    logic        sys_rst2, busy2;
    logic [3:0]  cause2;
    logic [15:0] viol_pc2;
    logic [1:0]  viol_cnt2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    viol_reset_ctrl #(.N_SRC(N_SRC), .HOLD_CYCLES(HOLD), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .viol_req(viol_req), .pc(pc), .cause_clr(cause_clr),
        .sys_rst(sys_rst), .busy(busy), .cause(cause), .viol_pc(viol_pc),
        .viol_cnt(viol_cnt)
    );

    viol_reset_ctrl #(.N_SRC(N_SRC), .HOLD_CYCLES(HOLD), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .viol_req(viol_req), .pc(pc), .cause_clr(cause_clr),
        .sys_rst(sys_rst2), .busy(busy2), .cause(cause2), .viol_pc(viol_pc2),
        .viol_cnt(viol_cnt2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    logic [3:0]  m_prev;
    logic [3:0]  m_cause;
    logic [15:0] m_pc;
    int          m_cnt;     // unbounded; each instance saturates differently
    int          m_rem;     // reset cycles still to come, including this one
    bit          m_valid = 1'b0;

    function automatic int sat(input int v, input int maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    always @(posedge clk) begin
        logic [3:0] e;
        if (rst === 1'b1) begin
            m_prev  = 4'b1111;
            m_cause = '0;
            m_pc    = '0;
            m_cnt   = 0;
            m_rem   = HOLD;
            m_valid = 1'b1;
        end else if (m_valid) begin
            e      = viol_req & ~m_prev;
            m_prev = viol_req;
            if ((e != 0) && ((m_cause == 0) || cause_clr)) m_pc = pc;
            m_cause = cause_clr ? e : (m_cause | e);
            if (cause_clr)   m_cnt = (e != 0) ? 1 : 0;
            else if (e != 0) m_cnt = m_cnt + 1;
            if (e != 0)          m_rem = HOLD;
            else if (m_rem > 0)  m_rem = m_rem - 1;
        end
    end

    // Single compare process: every cycle once the model is live.
    always @(negedge clk) begin
        if (m_valid) begin
            check("sys_rst",   32'(sys_rst),   32'(m_rem > 0));
            check("busy",      32'(busy),      32'(m_rem > 0));
            check("cause",     32'(cause),     32'(m_cause));
            check("viol_pc",   32'(viol_pc),   32'(m_pc));
            check("viol_cnt",  32'(viol_cnt),  32'(sat(m_cnt, 255)));
            check("sys_rst2",  32'(sys_rst2),  32'(m_rem > 0));
            check("viol_cnt2", 32'(viol_cnt2), 32'(sat(m_cnt, 3)));
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Counts consecutive high sys_rst cycles starting at the current
    // negedge; bounded so a stuck reset cannot hang the run.
    task automatic count_high(output int n);
        n = 0;
        while ((sys_rst === 1'b1) && (n < 40)) begin
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        int n;
        rst = 1'b1; viol_req = 4'b0001; pc = 16'h0000; cause_clr = 1'b0;

        // Power-up: request held through reset must not count.
        cyc(3);
        rst = 1'b0;
        count_high(n);
        check("pwrup_len", 32'(n), 32'd8);
        check("pwrup_cause", 32'(cause), 32'h0);
        check("pwrup_cnt", 32'(viol_cnt), 32'h0);
        $display("power-up: pulse %0d cycles, cause=%b cnt=%0d", n, cause, viol_cnt);

        // Single event, request stays high afterwards.
        viol_req = 4'b0000; cyc(2);
        pc = 16'hE010; viol_req = 4'b0001; cyc(1);
        check("single_cause", 32'(cause), 32'h1);
        check("single_pc", 32'(viol_pc), 32'hE010);
        check("single_cnt", 32'(viol_cnt), 32'd1);
        count_high(n);
        check("single_len", 32'(n), 32'd8);
        cyc(10);
        check("single_no_repeat", 32'(sys_rst), 32'd0);
        $display("single: pulse %0d cycles, pc=%h", n, viol_pc);

        // Retrigger: bit 2 rises in HOLD cycle 3.
        viol_req = 4'b0000; cause_clr = 1'b1; cyc(1);
        cause_clr = 1'b0;
        pc = 16'hE010; viol_req = 4'b0001; cyc(3);
        pc = 16'hE020; viol_req = 4'b0101;
        count_high(n);
        check("retrig_len", 32'(n + 2), 32'd11);
        check("retrig_cause", 32'(cause), 32'h5);
        check("retrig_pc", 32'(viol_pc), 32'hE010);
        check("retrig_cnt", 32'(viol_cnt), 32'd2);
        $display("retrigger: pulse %0d cycles, cause=%b cnt=%0d", n + 2, cause, viol_cnt);

        // Re-arm bit 0 after one low cycle.
        viol_req = 4'b0100; cyc(1);
        viol_req = 4'b0101; cyc(1);
        check("rearm_cnt", 32'(viol_cnt), 32'd3);
        count_high(n);
        check("rearm_len", 32'(n), 32'd8);
        $display("re-arm: pulse %0d cycles, cnt=%0d", n, viol_cnt);

        // Bits 1 and 3 together count once.
        viol_req = 4'b1111; cyc(1);
        check("simul_cnt", 32'(viol_cnt), 32'd4);
        count_high(n);
        $display("simultaneous: cnt=%0d cause=%b", viol_cnt, cause);

        // Clear in the same cycle as a bit 1 edge.
        viol_req = 4'b0000; cyc(1);
        pc = 16'hE030; viol_req = 4'b0010; cause_clr = 1'b1; cyc(1);
        cause_clr = 1'b0;
        check("clrset_cause", 32'(cause), 32'h2);
        check("clrset_cnt", 32'(viol_cnt), 32'd1);
        check("clrset_pc", 32'(viol_pc), 32'hE030);
        $display("clear+set: cause=%b cnt=%0d pc=%h", cause, viol_cnt, viol_pc);
        count_high(n);

        // Five more events: narrow counter saturates at 3.
        for (int i = 0; i < 5; i++) begin
            viol_req = 4'b0011; cyc(1);
            viol_req = 4'b0010; cyc(1);
        end
        check("sat_cnt8", 32'(viol_cnt), 32'd6);
        check("sat_cnt2", 32'(viol_cnt2), 32'd3);
        $display("saturation: cnt8=%0d cnt2=%0d", viol_cnt, viol_cnt2);

        // Reset in the middle of the pulse.
        cyc(2);
        rst = 1'b1; cyc(1);
        rst = 1'b0;
        check("midrst_cause", 32'(cause), 32'h0);
        check("midrst_cnt", 32'(viol_cnt), 32'd0);
        check("midrst_pc", 32'(viol_pc), 32'h0);
        count_high(n);
        check("midrst_len", 32'(n), 32'd8);
        $display("mid-pulse reset: pulse %0d cycles", n);

        // Random traffic, checked cycle by cycle against the model.
        for (int i = 0; i < 600; i++) begin
            logic [3:0] flip;
            for (int b = 0; b < 4; b++) flip[b] = ($urandom_range(0, 3) == 0);
            viol_req  = viol_req ^ flip;
            pc        = 16'($urandom);
            cause_clr = ($urandom_range(0, 15) == 0);
            rst       = ($urandom_range(0, 99) == 0);
            cyc(1);
        end
        rst = 1'b0; cause_clr = 1'b0;
        cyc(2);
        $display("random phase: 600 cycles");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
